imm_ext_arbiter: RTL
====================

// Module: imm_ext_arbiter
// PURPOSE
//  Shares one 16->32 immediate extension unit between two requesters
//  (requester 0 = ID-stage decode, requester 1 = branch-target unit).
//  Arbitrates round-robin, extends the granted immediate (sign, zero or
//  LUI) and holds the registered result in a single output slot under a
//  valid/ready handshake. Sits between decode and the ALU operand mux.
// PARAMETERS
//  IMM_W      16  immediate input width
//  OUT_W      32  extended output width (OUT_W > IMM_W)
//  FIXED_PRI  0   0 = round-robin; 1 = requester 0 always wins
// PORTS
//  Clk       in   1      clock, all state updates on rising edge
//  Rst_n     in   1      synchronous reset, active-low
//  Req0      in   1      requester 0 has an immediate; held until Ack0
//  Imm0      in   IMM_W  requester 0 immediate
//  Mode0     in   2      00 sign, 01 zero, 10 LUI, 11 reserved (= sign)
//  Ack0      out  1      combinational; request 0 accepted this cycle
//  Req1/Imm1/Mode1/Ack1  same as requester 0, for requester 1
//  OutValid  out  1      OutData/OutId hold a result
//  OutData   out  OUT_W  extended immediate
//  OutId     out  1      requester that owns OutData
//  OutReady  in   1      consumer takes result when OutValid & OutReady
// BEHAVIOUR
//  - Reset (Rst_n=0 at edge): OutValid=0, OutData=0, OutId=0, priority
//    pointer=0 (requester 0 preferred). Ack0/Ack1 are 0 while Rst_n=0.
//  - Slot free: free = ~OutValid | OutReady.
//  - Grant (combinational): if free and exactly one Req, grant it; if both,
//    grant pointer's requester (FIXED_PRI=1: always 0). Ack of granted
//    requester =1, other =0. No grant when ~free: Acks stay 0, Req holds.
//  - Capture at edge on grant: OutData = extend(Imm, Mode), OutId = grant,
//    OutValid=1. Latency: Ack cycle N -> OutValid at N+1.
//  - On grant, pointer moves to the non-granted requester; pointer is
//    unchanged in cycles with no grant.
//  - Pop without grant (OutValid & OutReady, no Req): OutValid=0 next
//    edge; OutData/OutId keep last value.
//  - Pop with grant same cycle: slot refilled, OutValid stays 1 ->
//    throughput one result per cycle.
//  - OutValid & ~OutReady: OutData/OutId/OutValid stable (no change).
//  - Extension: sign -> {{(OUT_W-IMM_W){Imm[IMM_W-1]}}, Imm};
//    zero -> {{(OUT_W-IMM_W){1'b0}}, Imm}; mode 11 treated as sign.
//  - FSM: IDLE (OutValid=0) / FULL (OutValid=1). IDLE->FULL on grant;
//    FULL->IDLE on pop w/o grant; FULL->FULL on stall or pop+grant.
//  - Reset mid-operation discards held result; pending Reqs re-arbitrated
//    after reset from pointer=0.
// CONFIGURATION
//  IMM_EXT_LUI_EN defined: Mode 10 -> OutData = Imm << (OUT_W-IMM_W),
//    low bits zero (e.g. 16'h1234 -> 32'h1234_0000).
//  IMM_EXT_LUI_EN undefined: Mode 10 treated as sign-extend; no shifter.
// TESTING
//  1 Reset: Rst_n=0 two cycles -> OutValid=0, OutData=0, Ack0=Ack1=0.
//  2 Req0, Imm0=16'h8001, Mode0=00 -> Ack0 same cycle; next cycle
//    OutValid=1, OutData=32'hFFFF_8001, OutId=0. Mode0=01 -> 32'h0000_8001.
//  3 Req0=Req1=1 held, OutReady=1 -> Acks alternate 0,1,0,1; OutId
//    sequence 0,1,0,1 on consecutive cycles (FIXED_PRI=1: always 0).
//  4 OutValid=1, OutReady=0 for 3 cycles with Req1=1 -> Ack1=0, OutData
//    stable; OutReady=1 -> Ack1=1 that cycle, new data next cycle.
//  5 Mode=10, Imm=16'h1234: with IMM_EXT_LUI_EN -> 32'h1234_0000;
//    without -> 32'h0000_1234.
//  6 Rst_n=0 while OutValid=1 -> OutValid=0 next edge; pointer back to 0.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one 16->32 immediate extender
// between two requesters, with a single registered output slot. Optional LUI mode: IMM_EXT_LUI_EN.
module imm_ext_arbiter #(
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req0,
  input  logic [IMM_W-1:0] Imm0,
  input  logic [1:0]       Mode0,
  output logic             Ack0,
  input  logic             Req1,
  input  logic [IMM_W-1:0] Imm1,
  input  logic [1:0]       Mode1,
  output logic             Ack1,
  output logic             OutValid,
  output logic [OUT_W-1:0] OutData,
  output logic             OutId,
  input  logic             OutReady
);

  typedef enum logic {StIdle, StFull} state_e;

  state_e             r_state;
  logic               r_ptr;
  logic [OUT_W-1:0]   r_data;
  logic               r_id;

  logic               w_free;
  logic               w_gnt;
  logic               w_gnt_id;
  logic [IMM_W-1:0]   w_imm;
  logic [1:0]         w_mode;
  logic [OUT_W-1:0]   w_ext;

  function automatic logic [OUT_W-1:0] f_extend(input logic [IMM_W-1:0] imm,
                                                input logic [1:0]       mode);
    logic [OUT_W-1:0] ext;
    unique case (mode)
      2'b01:   ext = {{(OUT_W-IMM_W){1'b0}}, imm};
`ifdef IMM_EXT_LUI_EN
      2'b10:   ext = {{(OUT_W-IMM_W){1'b0}}, imm} << (OUT_W-IMM_W);
`endif
      // Reserved mode 11 (and 10 without LUI support) falls back to sign-extend.
      default: ext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    endcase
    return ext;
  endfunction

  assign OutValid = (r_state == StFull);
  assign OutData  = r_data;
  assign OutId    = r_id;

  always_comb begin
    w_free   = ~OutValid | OutReady;
    w_gnt    = Rst_n & w_free & (Req0 | Req1);
    w_gnt_id = 1'b0;
    if (Req0 && Req1) begin
      w_gnt_id = (FIXED_PRI != 0) ? 1'b0 : r_ptr;
    end else if (Req1) begin
      w_gnt_id = 1'b1;
    end
    Ack0   = w_gnt & ~w_gnt_id;
    Ack1   = w_gnt & w_gnt_id;
    w_imm  = w_gnt_id ? Imm1 : Imm0;
    w_mode = w_gnt_id ? Mode1 : Mode0;
    w_ext  = f_extend(w_imm, w_mode);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= StIdle;
      r_ptr   <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_ptr  <= ~w_gnt_id;
        r_data <= w_ext;
        r_id   <= w_gnt_id;
      end
      unique case (r_state)
        StIdle: if (w_gnt) r_state <= StFull;
        StFull: if (!w_gnt && OutReady) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
